// File: rtl/aes444_pkg.sv
// aes444_pkg: shared controller state encoding, data width and default core latency
package aes444_pkg;
  localparam int DW = 64;
  localparam int CORE_LAT_DEF = 11;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, HOLD} state_t;
endpackage

// File: rtl/aes444_ctrl_if.sv
// aes444_ctrl_if: request (key + plaintext) and ciphertext result handshakes
// master: issues requests and consumes results; slave: the controller
interface aes444_ctrl_if;
  import aes444_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in_key;
  logic [DW-1:0] in_text;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  modport master(output in_valid, in_key, in_text, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_key, in_text, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes444_ctrl.sv
// aes444_ctrl: sequences one request at a time through an external AES444 core
// Ports: clk, rst (async, active-high, shared with the core); bus (aes444_ctrl_if.slave);
// busy (not IDLE); core_start/core_key/core_text to the core; core_text_out from the core.
// Build option AES444_CTRL_KEYCACHE_EN: skip LOAD when the new key equals the loaded one.
module aes444_ctrl
  import aes444_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  aes444_ctrl_if.slave  bus,
  output logic          busy,
  output logic          core_start,
  output logic [DW-1:0] core_key,
  output logic [DW-1:0] core_text,
  input  logic [DW-1:0] core_text_out
);
  localparam logic [3:0] LAST = 4'(CORE_LAT - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [DW-1:0] key_reg, text_reg;
  logic accept, slot_free, at_end, capture, hit;
  assign accept = bus.in_valid && bus.in_ready;
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign at_end = cnt == LAST;
  assign capture = ((state == WAIT && at_end) || state == HOLD) && slot_free;
  assign bus.in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign core_start = state == START;
  assign core_key = key_reg;
  assign core_text = text_reg;
`ifdef AES444_CTRL_KEYCACHE_EN
  logic key_valid;
  assign hit = key_valid && bus.in_key == key_reg;
  always_ff @(posedge clk or posedge rst)
    if (rst) key_valid <= 1'b0;
    else if (state == LOAD) key_valid <= 1'b1;
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = accept ? (hit ? START : LOAD) : IDLE;
      LOAD:  state_n = START;
      START: state_n = WAIT;
      WAIT:  state_n = at_end ? (slot_free ? IDLE : HOLD) : WAIT;
      HOLD:  state_n = slot_free ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // A capture coinciding with out_ready replaces the taken result without a bubble.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      key_reg <= '0;
      text_reg <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
    end else begin
      cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
      if (accept) begin
        key_reg <= bus.in_key;
        text_reg <= bus.in_text;
      end
      if (capture) bus.out_data <= core_text_out;
      bus.out_valid <= capture || (bus.out_valid && !bus.out_ready);
    end
endmodule

// File: tb/tb_aes444_ctrl.sv
// tb_aes444_ctrl: directed bench for aes444_ctrl with a behavioural SR(10,4,4,4) core
module tb_aes444_ctrl;
  import aes444_pkg::*;
  localparam int LAT = CORE_LAT_DEF;
  localparam logic [3:0] SBOX [16] = '{4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
                                       4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, core_start;
  logic [63:0] core_key, core_text, core_text_out;
  int checks = 0;
  int errors = 0;
  aes444_ctrl_if bus();
  aes444_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .core_start(core_start),
    .core_key(core_key), .core_text(core_text), .core_text_out(core_text_out)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return p;
  endfunction
  // Nibble (r,c) lives at column-major index 4*c+r, index 0 in the top nibble.
  function automatic logic [63:0] cipher(input logic [63:0] key, input logic [63:0] text);
    logic [3:0] s [4][4];
    logic [3:0] k [4][4];
    logic [3:0] t [4][4];
    logic [3:0] rc;
    logic [63:0] o;
    rc = 4'h1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        k[r][c] = key[63-4*(4*c+r) -: 4];
        s[r][c] = text[63-4*(4*c+r) -: 4] ^ k[r][c];
      end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++) k[r][0] ^= SBOX[k[(r+1)%4][3]] ^ (r == 0 ? rc : 4'h0);
      for (int c = 1; c < 4; c++)
        for (int r = 0; r < 4; r++) k[r][c] ^= k[r][c-1];
      rc = gm(rc, 4'h2);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = SBOX[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = (rd == 10 ? t[r][c] : gm(4'h2, t[r][c]) ^ gm(4'h3, t[(r+1)%4][c])
                     ^ t[(r+2)%4][c] ^ t[(r+3)%4][c]) ^ k[r][c];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[63-4*(4*c+r) -: 4] = s[r][c];
    return o;
  endfunction
  // Core model: key register follows core_key while idle, result appears LAT cycles after start.
  logic [63:0] key_r, run_key, text_r;
  int t;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_r <= '0;
      run_key <= '0;
      text_r <= '0;
      t <= 0;
      core_text_out <= '0;
    end else begin
      if (t == 0) key_r <= core_key;
      if (core_start) begin
        run_key <= key_r;
        text_r <= core_text;
        t <= 1;
        core_text_out <= 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (t == LAT - 1) begin
        core_text_out <= cipher(run_key, text_r);
        t <= 0;
      end else if (t != 0) t <= t + 1;
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_req(input string tag, input logic [63:0] k, input logic [63:0] x, input int lat);
    int n;
    bus.in_key = k;
    bus.in_text = x;
    bus.in_valid = 1'b1;
    chk({tag, " accept"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " data"}, bus.out_data, cipher(k, x));
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [63:0] r1, r2, r3, r4;
    logic seen;
    bus.in_valid = 1'b0;
    bus.in_key = '0;
    bus.in_text = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst core_start", 64'(core_start), 64'd0);
    chk("rst core_key", core_key, 64'd0);
    chk("rst core_text", core_text, 64'd0);
    chk("rst out_data", bus.out_data, 64'd0);
    rst = 1'b0;
    chk("post rst in_ready", 64'(bus.in_ready), 64'd1);
    // single request, zero key and text
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    chk("t1 accept", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("t1 in_ready A+1", 64'(bus.in_ready), 64'd0);
    chk("t1 busy A+1", 64'(busy), 64'd1);
    chk("t1 start A+1", 64'(core_start), 64'd0);
    tick();
    chk("t1 start A+2", 64'(core_start), 64'd1);
    tick();
    chk("t1 start A+3", 64'(core_start), 64'd0);
    for (int i = 4; i < 14; i++) begin
      tick();
      chk("t1 early out_valid", 64'(bus.out_valid), 64'd0);
    end
    tick();
    chk("t1 out_valid A+14", 64'(bus.out_valid), 64'd1);
    chk("t1 data", bus.out_data, cipher(64'h0, 64'h0));
    tick();
    chk("t1 out_valid A+15", 64'(bus.out_valid), 64'd0);
    chk("t1 busy A+15", 64'(busy), 64'd0);
    // back-pressure: second result parks in HOLD
    r1 = cipher(64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD);
    r2 = cipher(64'h5555_6666_7777_8888, 64'h0123_4567_89AB_CDEF);
    bus.out_ready = 1'b0;
    bus.in_key = 64'h1111_2222_3333_4444;
    bus.in_text = 64'hAAAA_BBBB_CCCC_DDDD;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (13) tick();
    chk("t2 r1 valid", 64'(bus.out_valid), 64'd1);
    chk("t2 r1 data", bus.out_data, r1);
    chk("t2 in_ready overlap", 64'(bus.in_ready), 64'd1);
    bus.in_key = 64'h5555_6666_7777_8888;
    bus.in_text = 64'h0123_4567_89AB_CDEF;
    bus.in_valid = 1'b1;
    chk("t2 core_key held", core_key, 64'h1111_2222_3333_4444);
    tick();
    bus.in_valid = 1'b0;
    chk("t2 core_key new", core_key, 64'h5555_6666_7777_8888);
    chk("t2 core_text new", core_text, 64'h0123_4567_89AB_CDEF);
    repeat (13) tick();
    chk("t2 hold busy", 64'(busy), 64'd1);
    chk("t2 hold in_ready", 64'(bus.in_ready), 64'd0);
    chk("t2 hold r1 data", bus.out_data, r1);
    repeat (3) tick();
    chk("t2 hold r1 stable", bus.out_data, r1);
    chk("t2 hold r1 valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("t2 r2 valid", 64'(bus.out_valid), 64'd1);
    chk("t2 r2 data", bus.out_data, r2);
    chk("t2 idle", 64'(busy), 64'd0);
    tick();
    chk("t2 drained", 64'(bus.out_valid), 64'd0);
    // out_ready coinciding with capture
    r3 = cipher(64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0);
    r4 = cipher(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.out_ready = 1'b0;
    bus.in_key = 64'hFEDC_BA98_7654_3210;
    bus.in_text = 64'h0F0F_0F0F_F0F0_F0F0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (13) tick();
    bus.in_key = 64'h0000_0000_0000_0001;
    bus.in_text = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (12) tick();
    chk("t3 r3 before", bus.out_data, r3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t3 valid kept", 64'(bus.out_valid), 64'd1);
    chk("t3 r4 data", bus.out_data, r4);
    chk("t3 no hold", 64'(busy), 64'd0);
    tick();
    chk("t3 r4 held", bus.out_data, r4);
    chk("t3 r4 valid held", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("t3 drained", 64'(bus.out_valid), 64'd0);
    // reset in WAIT with cnt=5
    bus.in_key = 64'h1357_9BDF_2468_ACE0;
    bus.in_text = 64'h8000_0000_0000_0000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("t4 rst busy", 64'(busy), 64'd0);
    chk("t4 rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("t4 rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4 rst core_start", 64'(core_start), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("t4 release in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= bus.out_valid;
    end
    chk("t4 no stray output", 64'(seen), 64'd0);
    run_req("t4 after rst", 64'h2468_ACE0_1357_9BDF, 64'h0000_0000_0000_0080, 14);
    // repeated key: skips LOAD only with the key cache built in
`ifdef AES444_CTRL_KEYCACHE_EN
    run_req("t5 key first", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 14);
    run_req("t5 key repeat", 64'h0123_4567_89AB_CDEF, 64'h2222_2222_2222_2222, 13);
    run_req("t5 key other", 64'hCAFE_F00D_1234_5678, 64'h3333_3333_3333_3333, 14);
`else
    run_req("t5 key first", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 14);
    run_req("t5 key repeat", 64'h0123_4567_89AB_CDEF, 64'h2222_2222_2222_2222, 14);
    run_req("t5 key other", 64'hCAFE_F00D_1234_5678, 64'h3333_3333_3333_3333, 14);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
